sp_word_packer: RTL and testbench
=================================

# sp_word_packer

Packs LOG2_RATIO-defined groups of narrow words into one wide word, using RTS/RTR handshakes on both sides. It sits directly downstream of an sp_fifo and consumes that FIFO's OUT_RTS/OUT_RTR/OUT_DAT port. Its wide output feeds a wider datapath stage or a wider sp_fifo instance. The output is registered, and the block sustains one narrow word per cycle when downstream is always ready.

## Interface
- WORDLENGTH, 8: width of one input word.
- LOG2_RATIO, 2: log2 of words packed per output; RATIO = 2^LOG2_RATIO; legal range 1..4.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- IN_RTS  in  1  upstream (FIFO) has a word.
- IN_RTR  out  1  packer can accept a word.
- IN_DAT  in  WORDLENGTH  input word.
- OUT_RTS  out  1  packed word valid.
- OUT_RTR  in  1  downstream can accept.
- OUT_DAT  out  WORDLENGTH*RATIO  packed word; lane k = bits [k*WORDLENGTH +: WORDLENGTH].
- IN_LAST  in  1  (SP_PACKER_FLUSH_EN only) current word ends a group.
- OUT_LANES  out  LOG2_RATIO+1  (SP_PACKER_FLUSH_EN only) number of valid lanes in OUT_DAT, 1..RATIO.

## Operation
- in_xfc = IN_RTS & IN_RTR; out_xfc = OUT_RTS & OUT_RTR.
- Accumulator: RATIO-1 lane registers plus lane counter lane_cnt (LOG2_RATIO bits, reset 0).
- On in_xfc with lane_cnt < RATIO-1: write IN_DAT to lane[lane_cnt], then lane_cnt+1.
- On in_xfc with lane_cnt = RATIO-1 (completing word): load OUT_DAT = {IN_DAT, lane[RATIO-2..0]}, set OUT_RTS, and wrap lane_cnt to 0.
- First accepted word lands in lane 0 (LSBs).
- Output state machine has two states:
  - EMPTY (OUT_RTS=0): a completing in_xfc goes to FULL.
  - FULL (OUT_RTS=1): out_xfc without a completing in_xfc goes to EMPTY. out_xfc together with a completing in_xfc stays FULL, with OUT_DAT replaced by the new word.
- IN_RTR = reset deasserted AND NOT (lane_cnt = RATIO-1 AND OUT_RTS AND NOT OUT_RTR).
  - The combinational path OUT_RTR→IN_RTR is intentional; it gives no bubble at a full boundary.
- Non-completing words are always accepted, including while FULL.
- OUT_DAT holds stable while OUT_RTS=1 and OUT_RTR=0.
- Lane registers are not cleared on wrap; stale contents are overwritten before reuse.

## Timing
- Reset (asynchronous, while reset=0) forces:
  - OUT_RTS=0, OUT_DAT=0, lane_cnt=0, state EMPTY.
  - IN_RTR=0 (combinationally gated by reset).
  - OUT_LANES=0.
- First clock after reset deassertion: IN_RTR=1.
- Latency: OUT_RTS rises on the clock edge of the RATIO-th in_xfc, so it is visible one cycle after that word is presented.
- Throughput: with OUT_RTR tied 1, one in_xfc per cycle indefinitely and one output every RATIO cycles.
- Backpressure: when FULL, lane_cnt=RATIO-1 and OUT_RTR=0, IN_RTR=0 until OUT_RTR=1. In that cycle both transfers occur.
- IN_DAT is sampled only on in_xfc; IN_RTS dropping mid-group leaves lane_cnt unchanged.
- Reset asserted mid-group discards the partial group and any held output word.

## Configuration
- Macro: SP_PACKER_FLUSH_EN.
- Defined:
  - An in_xfc with IN_LAST=1 completes the group regardless of lane_cnt.
  - Lanes above lane_cnt are driven 0, OUT_LANES = lane_cnt+1, and lane_cnt wraps to 0.
  - The IN_RTR blocking term becomes (lane_cnt = RATIO-1 OR IN_LAST) AND OUT_RTS AND NOT OUT_RTR.
  - IN_LAST on a word at lane_cnt=RATIO-1 behaves as a normal completion with OUT_LANES=RATIO.
- Undefined: the IN_LAST and OUT_LANES ports are absent, and every output carries RATIO lanes.

## Structure
- Shared package sp_pkg holds:
  - the RTS/RTR transfer-state encoding (EMPTY=1'b0, FULL=1'b1);
  - a lane-count width helper (LOG2_RATIO+1).
- sp_fifo uses the same package.
- No sub-module: lane registers, counter and output register are local.
- The top-level test wrapper instantiates sp_fifo → sp_word_packer.

## Test plan
- WORDLENGTH=8, RATIO=4, OUT_RTR=1, feed 0x11,0x22,0x33,0x44 back-to-back → OUT_RTS one cycle after 4th transfer, OUT_DAT=0x44332211, IN_RTR never drops.
- Hold OUT_RTR=0, stream 8 words 0x01..0x08 → first output 0x04030201 held stable. IN_RTR falls while 0x08 is presented. Raising OUT_RTR gives out_xfc and in_xfc in the same cycle, and OUT_DAT becomes 0x08070605.
- IN_RTS toggling every other cycle over 4 words → same packed value; lane_cnt advances only on in_xfc.
- Assert reset=0 after 2 words and while an output is held → OUT_RTS=0, OUT_DAT=0, IN_RTR=0 immediately. After release, the next 4 words pack from lane 0.
- With SP_PACKER_FLUSH_EN, feed 0xAA, then 0xBB with IN_LAST=1 → OUT_DAT=0x0000BBAA, OUT_LANES=2. The next 4 words produce OUT_LANES=4.
- sp_fifo (LOG2_DEPTH=2) feeding the packer, 64 random words with random OUT_RTR → scoreboard matches every lane in order, with no loss or duplication.

Source files
------------

// File: rtl/sp_pkg.sv
// Shared RTS/RTR helpers for the sp_* blocks: transfer-state encoding and
// the lane-count width helper used by the packer's OUT_LANES port.
package sp_pkg;

   localparam logic XFER_EMPTY = 1'b0;
   localparam logic XFER_FULL  = 1'b1;

   // One extra bit so a count of RATIO lanes is representable.
   function automatic int lane_cnt_w(input int log2_ratio);
      return log2_ratio + 1;
   endfunction

endpackage

// File: rtl/sp_word_packer.sv
// Packs 2**LOG2_RATIO narrow RTS/RTR words into one registered wide word.
// Optional macro SP_PACKER_FLUSH_EN adds IN_LAST (short groups) and OUT_LANES.
module sp_word_packer
   import sp_pkg::*;
#(
   parameter int WORDLENGTH = 8,
   parameter int LOG2_RATIO = 2
)
(
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             IN_RTS,
   output logic                             IN_RTR,
   input  logic [WORDLENGTH-1:0]            IN_DAT,
   output logic                             OUT_RTS,
   input  logic                             OUT_RTR,
`ifdef SP_PACKER_FLUSH_EN
   input  logic                             IN_LAST,
   output logic [lane_cnt_w(LOG2_RATIO)-1:0] OUT_LANES,
`endif
   output logic [WORDLENGTH*(2**LOG2_RATIO)-1:0] OUT_DAT
);

   localparam int RATIO = 2 ** LOG2_RATIO;
   localparam int OUT_W = WORDLENGTH * RATIO;
   localparam logic [LOG2_RATIO-1:0] LAST_LANE = LOG2_RATIO'(RATIO - 1);

   logic [WORDLENGTH-1:0] lane_p0 [RATIO-1];
   logic [LOG2_RATIO-1:0] lane_cnt;
   logic [OUT_W-1:0]      packed_p0;
   logic [OUT_W-1:0]      out_dat_p1;
   logic                  vld_p1;
   logic                  complete;
   logic                  in_xfc;
   logic                  out_xfc;

`ifdef SP_PACKER_FLUSH_EN
   logic [lane_cnt_w(LOG2_RATIO)-1:0] lanes_p1;
   assign complete  = (lane_cnt == LAST_LANE) || IN_LAST;
   assign OUT_LANES = lanes_p1;
`else
   assign complete  = (lane_cnt == LAST_LANE);
`endif

   assign OUT_RTS = (vld_p1 == XFER_FULL);
   assign OUT_DAT = out_dat_p1;
   // OUT_RTR reaches IN_RTR combinationally so a full boundary costs no bubble.
   assign IN_RTR  = reset & ~(complete & OUT_RTS & ~OUT_RTR);
   assign in_xfc  = IN_RTS & IN_RTR;
   assign out_xfc = OUT_RTS & OUT_RTR;

   // Stage p0: lane accumulation and wide-word assembly
   always_ff @(posedge clk) begin
      for (int k = 0; k < RATIO - 1; k++)
         if (in_xfc && !complete && lane_cnt == LOG2_RATIO'(k))
            lane_p0[k] <= IN_DAT;
   end

   // Lanes above the current word stay zero, which is what a short group needs.
   always_comb begin
      packed_p0 = '0;
      for (int k = 0; k < RATIO - 1; k++)
         if (LOG2_RATIO'(k) < lane_cnt)
            packed_p0[k*WORDLENGTH +: WORDLENGTH] = lane_p0[k];
      for (int k = 0; k < RATIO; k++)
         if (LOG2_RATIO'(k) == lane_cnt)
            packed_p0[k*WORDLENGTH +: WORDLENGTH] = IN_DAT;
   end

   // Stage p1: registered output word and EMPTY/FULL state
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lane_cnt   <= '0;
         vld_p1     <= XFER_EMPTY;
         out_dat_p1 <= '0;
`ifdef SP_PACKER_FLUSH_EN
         lanes_p1   <= '0;
`endif
      end else begin
         if (in_xfc) begin
            if (complete) begin
               lane_cnt   <= '0;
               out_dat_p1 <= packed_p0;
`ifdef SP_PACKER_FLUSH_EN
               lanes_p1   <= {1'b0, lane_cnt} + 1'b1;
`endif
            end else begin
               lane_cnt <= lane_cnt + 1'b1;
            end
         end
         case (vld_p1)
            XFER_EMPTY: if (in_xfc && complete) vld_p1 <= XFER_FULL;
            default:    if (out_xfc && !(in_xfc && complete)) vld_p1 <= XFER_EMPTY;
         endcase
      end
   end

endmodule

// File: tb/tb_sp_word_packer.sv
// Self-checking bench for sp_word_packer: vector table, hand-written corner
// sequences and a randomized run scored against a queue-based packing model.
module tb_sp_word_packer;

   localparam int WL  = 8;
   localparam int L2R = 2;
   localparam int R   = 4;
   localparam int OW  = WL * R;

   logic          clk     = 1'b0;
   logic          reset   = 1'b1;
   logic          in_rts  = 1'b0;
   logic          out_rtr = 1'b0;
   logic [WL-1:0] in_dat  = '0;
   logic          in_rtr;
   logic          out_rts;
   logic [OW-1:0] out_dat;
`ifdef SP_PACKER_FLUSH_EN
   logic          in_last = 1'b0;
   logic [L2R:0]  out_lanes;
`endif

   int n_chk  = 0;
   int n_pass = 0;
   int acc_cnt = 0;

   sp_word_packer #(.WORDLENGTH(WL), .LOG2_RATIO(L2R)) dut (
      .clk(clk),
      .reset(reset),
      .IN_RTS(in_rts),
      .IN_RTR(in_rtr),
      .IN_DAT(in_dat),
      .OUT_RTS(out_rts),
      .OUT_RTR(out_rtr),
`ifdef SP_PACKER_FLUSH_EN
      .IN_LAST(in_last),
      .OUT_LANES(out_lanes),
`endif
      .OUT_DAT(out_dat)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, want %0h", nm, act, exp);
   endtask

   // Reference model: words accepted so far in the open group, and packed
   // words produced but not yet taken downstream.
   logic [WL-1:0] grp [$];
   logic [OW-1:0] expq [$];
   int            lanesq [$];

   always @(negedge clk) begin
      logic          lst;
      logic          want_rtr;
      logic          had_out;
      logic [OW-1:0] val;
      if (!reset) begin
         grp.delete();
         expq.delete();
         lanesq.delete();
      end else begin
         lst = 1'b0;
`ifdef SP_PACKER_FLUSH_EN
         lst = in_last;
`endif
         want_rtr = !(((grp.size() == R - 1) || lst) && expq.size() != 0 && !out_rtr);
         chk("m_in_rtr", in_rtr, want_rtr);
         chk("m_out_rts", out_rts, expq.size() != 0);
         had_out = (expq.size() != 0);
         if (had_out) begin
            chk("m_out_dat", out_dat, expq[0]);
`ifdef SP_PACKER_FLUSH_EN
            chk("m_out_lanes", out_lanes, lanesq[0]);
`endif
         end
         if (had_out && out_rtr) begin
            void'(expq.pop_front());
            void'(lanesq.pop_front());
         end
         if (in_rts && in_rtr) begin
            acc_cnt++;
            grp.push_back(in_dat);
            if (grp.size() == R || lst) begin
               val = '0;
               foreach (grp[i]) val = val | (OW'(grp[i]) << (WL * i));
               expq.push_back(val);
               lanesq.push_back(grp.size());
               grp.delete();
            end
         end
      end
   end

   typedef struct {
      logic          rts;
      logic [WL-1:0] dat;
      logic          rtr;
      logic          e_rtr;
      logic          e_rts;
      logic [OW-1:0] e_dat;
   } vec_t;

   vec_t tbl [$];

   task automatic cyc(input logic rts, input logic [WL-1:0] dat, input logic rtr);
      in_rts  = rts;
      in_dat  = dat;
      out_rtr = rtr;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int ncyc;
      #2 reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_rtr", in_rtr, 1'b0);
      chk("rst_out_rts", out_rts, 1'b0);
      chk("rst_out_dat", out_dat, '0);
`ifdef SP_PACKER_FLUSH_EN
      chk("rst_out_lanes", out_lanes, '0);
`endif
      reset = 1'b1;
      #1;
      chk("rel_in_rtr", in_rtr, 1'b1);

      // back-to-back, backpressure, then IN_RTS toggling
      tbl.push_back('{1, 8'h11, 1, 1, 0, 32'h0});
      tbl.push_back('{1, 8'h22, 1, 1, 0, 32'h0});
      tbl.push_back('{1, 8'h33, 1, 1, 0, 32'h0});
      tbl.push_back('{1, 8'h44, 1, 1, 1, 32'h44332211});
      tbl.push_back('{0, 8'h00, 1, 1, 0, 32'h0});
      for (int w = 1; w <= 3; w++) tbl.push_back('{1, WL'(w), 0, 1, 0, 32'h0});
      for (int w = 4; w <= 7; w++) tbl.push_back('{1, WL'(w), 0, 1, 1, 32'h04030201});
      tbl.push_back('{1, 8'h08, 0, 0, 1, 32'h04030201});
      tbl.push_back('{1, 8'h08, 0, 0, 1, 32'h04030201});
      tbl.push_back('{1, 8'h08, 1, 1, 1, 32'h08070605});
      tbl.push_back('{0, 8'h00, 1, 1, 0, 32'h0});
      tbl.push_back('{1, 8'h11, 1, 1, 0, 32'h0});
      tbl.push_back('{0, 8'hEE, 1, 1, 0, 32'h0});
      tbl.push_back('{1, 8'h22, 1, 1, 0, 32'h0});
      tbl.push_back('{0, 8'hEE, 1, 1, 0, 32'h0});
      tbl.push_back('{1, 8'h33, 1, 1, 0, 32'h0});
      tbl.push_back('{0, 8'hEE, 1, 1, 0, 32'h0});
      tbl.push_back('{1, 8'h44, 1, 1, 1, 32'h44332211});
      tbl.push_back('{0, 8'h00, 1, 1, 0, 32'h0});

      for (int i = 0; i < tbl.size(); i++) begin
         in_rts  = tbl[i].rts;
         in_dat  = tbl[i].dat;
         out_rtr = tbl[i].rtr;
         @(negedge clk);
         chk($sformatf("t%0d_in_rtr", i), in_rtr, tbl[i].e_rtr);
         @(posedge clk);
         #1;
         chk($sformatf("t%0d_out_rts", i), out_rts, tbl[i].e_rts);
         if (tbl[i].e_rts) chk($sformatf("t%0d_out_dat", i), out_dat, tbl[i].e_dat);
      end

      // reset while a word is held and a partial group is open
      for (int w = 0; w < 6; w++) cyc(1'b1, WL'(8'h31 + w), 1'b0);
      chk("pre_rst_held", out_rts, 1'b1);
      #1 reset = 1'b0;
      in_rts = 1'b0;
      #1;
      chk("mid_rst_out_rts", out_rts, 1'b0);
      chk("mid_rst_out_dat", out_dat, '0);
      chk("mid_rst_in_rtr", in_rtr, 1'b0);
      @(posedge clk);
      #1 reset = 1'b1;
      #1;
      chk("post_rst_in_rtr", in_rtr, 1'b1);
      for (int w = 0; w < 4; w++) cyc(1'b1, WL'(8'hA1 + w), 1'b1);
      chk("post_rst_out_rts", out_rts, 1'b1);
      chk("post_rst_out_dat", out_dat, 32'hA4A3A2A1);
      cyc(1'b0, '0, 1'b1);

`ifdef SP_PACKER_FLUSH_EN
      cyc(1'b1, 8'hAA, 1'b1);
      in_last = 1'b1;
      cyc(1'b1, 8'hBB, 1'b1);
      in_last = 1'b0;
      chk("flush_out_dat", out_dat, 32'h0000BBAA);
      chk("flush_out_lanes", out_lanes, 2);
      for (int w = 0; w < 4; w++) cyc(1'b1, WL'(8'hC1 + w), 1'b1);
      chk("full_out_dat", out_dat, 32'hC4C3C2C1);
      chk("full_out_lanes", out_lanes, 4);
      cyc(1'b0, '0, 1'b1);
`endif

      // randomized stream scored by the model
      acc_cnt = 0;
      ncyc = 0;
      while (acc_cnt < 64 && ncyc < 3000) begin
`ifdef SP_PACKER_FLUSH_EN
         in_last = ($urandom_range(0, 5) == 0);
`endif
         cyc($urandom_range(0, 9) < 7, WL'($urandom), 1'($urandom_range(0, 1)));
         ncyc++;
      end
      chk("rand_accepted", acc_cnt >= 64, 1'b1);
`ifdef SP_PACKER_FLUSH_EN
      in_last = 1'b0;
`endif
      ncyc = 0;
      while (grp.size() != 0 && ncyc < 50) begin
         cyc(1'b1, WL'($urandom), 1'b1);
         ncyc++;
      end
      cyc(1'b0, '0, 1'b1);
      cyc(1'b0, '0, 1'b1);
      chk("drain_model_empty", expq.size(), 0);
      chk("drain_out_rts", out_rts, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
